// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared types and constants for the bit-serial add/subtract
// sequencer.
//   sa_state_t       - sequencer FSM state encoding (IDLE, RUN, DONE)
//   SA_DEFAULT_WIDTH - default operand/result width in bits
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

    localparam int SA_DEFAULT_WIDTH = 64;

endpackage

// File: rtl/serial_add_full_adder.sv
// full_adder: single-bit full adder. This is the one piece of adder logic
// shared across every bit position of the serial sequencer.
// Ports:
//   a, b  - operand bits
//   cin   - carry in
//   sum   - a ^ b ^ cin
//   cout  - carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign sum  = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/serial_add_seq.sv
// serial_add_seq: bit-serial add/subtract sequencer. One full_adder is reused
// for all WIDTH bit positions, one bit per clock, LSB first.
// Ports:
//   clk, reset_n                - clock, asynchronous active-low reset
//   start_valid/start_ready     - operand handshake (ready only in IDLE)
//   a, b, sub                   - operands; sub=1 computes a + ~b + 1
//   result_valid/result_ready   - result handshake (valid only in DONE)
//   result, cout, overflow      - sum/difference, MSB carry out, signed overflow
module serial_add_seq
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    sa_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic fa_sum;
    logic fa_cout;

    full_adder u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    // Subtract is a + ~b + 1: invert b here and seed the
                    // carry with 1 so the shared adder never changes mode.
                    a_sh_d  = a;
                    b_sh_d  = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                res_d   = {fa_sum, res_q[WIDTH-1:1]};
                carry_d = fa_cout;
                if (cnt_q == LAST_BIT) begin
                    // carry_q is the carry into the MSB on this last bit.
                    cout_d  = fa_cout;
                    ovf_d   = carry_q ^ fa_cout;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign start_ready  = (state_q == IDLE);
    assign result_valid = (state_q == DONE);
    assign result       = res_q;
    assign cout         = cout_q;
    assign overflow     = ovf_q;

endmodule
